// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART slave with a one-byte TX holding
// register, a one-byte RX buffer, a programmable baud divisor and an irq
// that follows rx_full. Register map (addr): 0 DATA, 1 STAT, 2 CTRL, 3 DIV.
module uart_periph #(
    parameter int WIDTH       = 32,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 87
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wen,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             rxd,
    output logic             txd,
    output logic             irq
);

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_STAT = 2'd1;
    localparam logic [1:0] A_CTRL = 2'd2;
    localparam logic [1:0] A_DIV  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Bus write decode
    // ------------------------------------------------------------------
    logic w_wr;
    logic w_wr_data;
    logic w_wr_stat;
    logic w_wr_ctrl;
    logic w_wr_div;

    assign w_wr      = cs & wen;
    assign w_wr_data = w_wr & (addr == A_DATA);
    assign w_wr_stat = w_wr & (addr == A_STAT);
    assign w_wr_ctrl = w_wr & (addr == A_CTRL);
    assign w_wr_div  = w_wr & (addr == A_DIV);

    // Upper data bits are only meaningful for some registers.
    logic w_unused_din;
    assign w_unused_din = ^din;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [1:0]           r_ctrl;   // bit0 tx_en, bit1 rx_en
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] w_div_eff;

    // Divisors below 2 would leave no room for a mid-bit sample point.
    assign w_div_eff = (r_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : r_div;

    // CTRL and DIV are plain read/write registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= 2'b11;
            r_div  <= DIV_WIDTH'(DEFAULT_DIV);
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= din[1:0];
            end
            if (w_wr_div) begin
                r_div <= din[DIV_WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t               r_tx_state;
    logic [DIV_WIDTH-1:0] r_tx_cnt;
    logic [DIV_WIDTH-1:0] r_tx_div;
    logic [7:0]           r_tx_shift;
    logic [2:0]           r_tx_bit;
    logic                 r_txd;
    logic                 w_tx_bit_end;
    logic                 w_tx_busy;

    assign w_tx_bit_end = (r_tx_cnt == r_tx_div - DIV_WIDTH'(1));
    assign w_tx_busy    = (r_tx_state != S_IDLE);
    assign txd          = r_txd;

    // TX FSM: divisor latched at frame start so DIV writes only affect the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_div   <= DIV_WIDTH'(2);
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_wr_data && r_ctrl[0]) begin
                        r_tx_state <= S_START;
                        r_tx_cnt   <= '0;
                        r_tx_div   <= w_div_eff;
                        r_tx_shift <= din[7:0];
                        r_txd      <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_state <= S_DATA;
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + DIV_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= S_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_txd      <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + DIV_WIDTH'(1);
                    end
                end
                S_STOP: begin
                    if (w_tx_bit_end) begin
                        r_tx_state <= S_IDLE;
                        r_tx_cnt   <= '0;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    r_tx_state <= S_IDLE;
                    r_txd      <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic r_rxd_meta;
    logic r_rxd_sync;
    logic r_rxd_prev;
    logic w_rx_fall;

    // Two-flop synchroniser for the asynchronous line plus a delayed copy for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    // A start needs a genuine high-to-low transition, so a line stuck low
    // after a framing error cannot retrigger the receiver.
    assign w_rx_fall = r_rxd_prev & ~r_rxd_sync;

    state_t               r_rx_state;
    logic [DIV_WIDTH-1:0] r_rx_cnt;
    logic [DIV_WIDTH-1:0] r_rx_div;
    logic [7:0]           r_rx_shift;
    logic [2:0]           r_rx_bit;
    logic                 w_rx_half_end;
    logic                 w_rx_bit_end;
    logic                 w_rx_done;

    assign w_rx_half_end = (r_rx_cnt == (r_rx_div >> 1) - DIV_WIDTH'(1));
    assign w_rx_bit_end  = (r_rx_cnt == r_rx_div - DIV_WIDTH'(1));
    assign w_rx_done     = (r_rx_state == S_STOP) && w_rx_bit_end && r_ctrl[1];

    // RX FSM: validate start at half a bit, then sample each bit one period later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_div   <= DIV_WIDTH'(2);
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
        end else if (!r_ctrl[1]) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= S_START;
                        r_rx_cnt   <= '0;
                        r_rx_div   <= w_div_eff;
                    end
                end
                S_START: begin
                    if (w_rx_half_end) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= r_rxd_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + DIV_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= S_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + DIV_WIDTH'(1);
                    end
                end
                S_STOP: begin
                    if (w_rx_bit_end) begin
                        r_rx_state <= S_IDLE;
                        r_rx_cnt   <= '0;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    r_rx_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive buffer and status flags
    // ------------------------------------------------------------------
    logic [7:0] r_rx_data;
    logic       r_rx_full;
    logic       r_ovr;
    logic       r_ferr;
    logic       w_clr_full;

    assign w_clr_full = w_wr_stat & din[0];
    assign irq        = r_rx_full;

    // W1C first, completion second: a clear racing a completion loses to it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data <= '0;
            r_rx_full <= 1'b0;
            r_ovr     <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            if (w_wr_stat) begin
                if (din[0]) r_rx_full <= 1'b0;
                if (din[2]) r_ovr     <= 1'b0;
                if (din[3]) r_ferr    <= 1'b0;
            end
            if (w_rx_done) begin
                if (!r_rx_full || w_clr_full) begin
                    r_rx_data <= r_rx_shift;
                    r_rx_full <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
                if (!r_rxd_sync) begin
                    r_ferr <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux: purely combinational, no read side effects
    // ------------------------------------------------------------------
    // Register read-back, zero-extended to the bus width.
    always_comb begin
        dout = '0;
        case (addr)
            A_DATA:  dout = WIDTH'(r_rx_data);
            A_STAT:  dout = WIDTH'({r_ferr, r_ovr, w_tx_busy, r_rx_full});
            A_CTRL:  dout = WIDTH'(r_ctrl);
            default: dout = WIDTH'(r_div);
        endcase
    end

endmodule
